hub75_receiver: RTL and testbench

HUB75_RECEIVER -- requirements
Module: hub75_receiver

---
 rtl/hub75_receiver.sv | 175 +++++++++++++++++
 tb/tb_hub75_receiver.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_receiver.sv
// HUB-75 panel receiver: samples the asynchronous panel bus, rebuilds one row pair
// and replays it as a ready/valid stream of single-pixel writes (upper, then lower).
module hub75_receiver #(
  parameter int column_count      = 64,
  parameter int row_address_width = 5
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            hub_clk,
  input  logic                            hub_lat,
  input  logic                            hub_oe_n,
  input  logic [row_address_width-1:0]    hub_addr,
  input  logic [2:0]                      hub_rgb_upper,
  input  logic [2:0]                      hub_rgb_lower,
  output logic                            write_valid,
  input  logic                            write_ready,
  output logic [row_address_width:0]      write_row,
  output logic [$clog2(column_count)-1:0] write_column,
  output logic [2:0]                      write_rgb,
  output logic                            busy,
  output logic                            display_on,
  output logic                            frame_error,
  output logic                            overrun
);
  localparam int col_w = $clog2(column_count);
  localparam int cnt_w = $clog2(column_count + 2);
  localparam int bus_w = 3 + row_address_width + 6;
  localparam logic [col_w-1:0] last_col = col_w'(column_count - 1);
  localparam logic [cnt_w-1:0] cnt_full = cnt_w'(column_count);
  localparam logic [cnt_w-1:0] cnt_sat  = cnt_w'(column_count + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, READ = 1'b1} state_t;

  state_t                       state_r;
  logic [bus_w-1:0]             sync1_r;
  logic [bus_w-1:0]             sync2_r;
  logic                         clk_hist_r;
  logic                         lat_hist_r;
  logic [1:0]                   arm_count_r;
  logic [cnt_w-1:0]             shift_count_r;
  logic [2:0]                   shift_upper_r [column_count];
  logic [2:0]                   shift_lower_r [column_count];
  logic [2:0]                   read_upper_r  [column_count];
  logic [2:0]                   read_lower_r  [column_count];
  logic [row_address_width-1:0] read_addr_r;
  logic [row_address_width:0]   write_row_r;
  logic [col_w-1:0]             write_column_r;
  logic [2:0]                   write_rgb_r;
  logic                         display_on_r;
  logic                         frame_error_r;
  logic                         overrun_r;

  logic                         clk_s2_s;
  logic                         lat_s2_s;
  logic                         oe_n_s2_s;
  logic [row_address_width-1:0] addr_s2_s;
  logic [2:0]                   upper_s2_s;
  logic [2:0]                   lower_s2_s;
  logic                         armed_s;
  logic                         clk_rise_s;
  logic                         lat_rise_s;
  logic                         count_ok_s;
  logic                         last_beat_s;
  logic                         final_accept_s;
  logic                         start_s;
  logic [col_w-1:0]             next_col_s;

  assign {clk_s2_s, lat_s2_s, oe_n_s2_s, addr_s2_s, upper_s2_s, lower_s2_s} = sync2_r;

  assign write_valid  = (state_r == READ);
  assign busy         = (state_r == READ);
  assign write_row    = write_row_r;
  assign write_column = write_column_r;
  assign write_rgb    = write_rgb_r;
  assign display_on   = display_on_r;
  assign frame_error  = frame_error_r;
  assign overrun      = overrun_r;

  // Edge detection, latch qualification and beat bookkeeping
  always_comb begin
    armed_s        = (arm_count_r == 2'd3);
    clk_rise_s     = armed_s && clk_s2_s && !clk_hist_r;
    lat_rise_s     = armed_s && lat_s2_s && !lat_hist_r;
    count_ok_s     = (shift_count_r == cnt_full);
    last_beat_s    = (write_column_r == last_col) && write_row_r[row_address_width];
    final_accept_s = (state_r == READ) && write_ready && last_beat_s;
    start_s        = lat_rise_s && count_ok_s && ((state_r == IDLE) || final_accept_s);
    next_col_s     = write_column_r + col_w'(1);
  end

  // Pixel shift line and readout snapshot; the snapshot is only written on a valid latch
  always_ff @(posedge clock) begin
    if (clk_rise_s) begin
      shift_upper_r[0] <= upper_s2_s;
      shift_lower_r[0] <= lower_s2_s;
      for (int i = 1; i < column_count; i++) begin
        shift_upper_r[i] <= shift_upper_r[i-1];
        shift_lower_r[i] <= shift_lower_r[i-1];
      end
    end
    if (start_s) begin
      read_upper_r <= shift_upper_r;
      read_lower_r <= shift_lower_r;
      read_addr_r  <= addr_s2_s;
    end
  end

  // Synchronizers, shift counter, status pulses and readout FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r        <= {bus_w{1'b0}};
      sync2_r        <= {bus_w{1'b0}};
      clk_hist_r     <= 1'b0;
      lat_hist_r     <= 1'b0;
      arm_count_r    <= 2'd0;
      shift_count_r  <= {cnt_w{1'b0}};
      display_on_r   <= 1'b0;
      frame_error_r  <= 1'b0;
      overrun_r      <= 1'b0;
      state_r        <= IDLE;
      write_row_r    <= {(row_address_width+1){1'b0}};
      write_column_r <= {col_w{1'b0}};
      write_rgb_r    <= 3'd0;
    end else begin
      sync1_r    <= {hub_clk, hub_lat, hub_oe_n, hub_addr, hub_rgb_upper, hub_rgb_lower};
      sync2_r    <= sync1_r;
      clk_hist_r <= clk_s2_s;
      lat_hist_r <= lat_s2_s;
      // Hold off edge detection until the synchronizer reflects the real bus
      if (arm_count_r != 2'd3) begin
        arm_count_r <= arm_count_r + 2'd1;
      end
      display_on_r  <= armed_s && !oe_n_s2_s;
      frame_error_r <= lat_rise_s && !count_ok_s;
      overrun_r     <= lat_rise_s && (state_r == READ) && !final_accept_s;

      if (lat_rise_s) begin
        shift_count_r <= {cnt_w{1'b0}};
      end else if (clk_rise_s && (shift_count_r != cnt_sat)) begin
        shift_count_r <= shift_count_r + cnt_w'(1);
      end

      if (start_s) begin
        state_r        <= READ;
        write_column_r <= {col_w{1'b0}};
        write_row_r    <= {1'b0, addr_s2_s};
        write_rgb_r    <= shift_upper_r[0];
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= IDLE;
          end
          READ: begin
            if (write_ready) begin
              if (last_beat_s) begin
                state_r <= IDLE;
              end else if (!write_row_r[row_address_width]) begin
                write_row_r <= {1'b1, read_addr_r};
                write_rgb_r <= read_lower_r[write_column_r];
              end else begin
                write_column_r <= next_col_s;
                write_row_r    <= {1'b0, read_addr_r};
                write_rgb_r    <= read_upper_r[next_col_s];
              end
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hub75_receiver.sv
// Directed self-checking bench for hub75_receiver with 4 columns and a 2-bit row address.
module tb_hub75_receiver;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       hub_clk = 1'b0;
  logic       hub_lat = 1'b0;
  logic       hub_oe_n = 1'b1;
  logic [1:0] hub_addr = 2'd0;
  logic [2:0] hub_rgb_upper = 3'd0;
  logic [2:0] hub_rgb_lower = 3'd0;
  logic       write_valid;
  logic       write_ready = 1'b0;
  logic [2:0] write_row;
  logic [1:0] write_column;
  logic [2:0] write_rgb;
  logic       busy;
  logic       display_on;
  logic       frame_error;
  logic       overrun;

  int         n_checks = 0;
  int         n_fail = 0;
  int         ov_cnt = 0;
  int         fe;
  int         ov;
  int         vh;
  logic [7:0] exp_beats [16];

  hub75_receiver #(.column_count(4), .row_address_width(2)) dut (
    .clock(clock), .reset(reset), .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe_n(hub_oe_n),
    .hub_addr(hub_addr), .hub_rgb_upper(hub_rgb_upper), .hub_rgb_lower(hub_rgb_lower),
    .write_valid(write_valid), .write_ready(write_ready), .write_row(write_row),
    .write_column(write_column), .write_rgb(write_rgb), .busy(busy), .display_on(display_on),
    .frame_error(frame_error), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] beat(input logic [2:0] r, input logic [1:0] c, input logic [2:0] g);
    return {r, c, g};
  endfunction

  function automatic logic [7:0] payload();
    return {write_row, write_column, write_rgb};
  endfunction

  // Line A: upper 1,2,3,4 / lower 5,6,7,0 at address 2
  task automatic set_exp_a(input int base);
    exp_beats[base+0] = beat(3'd2, 2'd0, 3'd4);
    exp_beats[base+1] = beat(3'd6, 2'd0, 3'd0);
    exp_beats[base+2] = beat(3'd2, 2'd1, 3'd3);
    exp_beats[base+3] = beat(3'd6, 2'd1, 3'd7);
    exp_beats[base+4] = beat(3'd2, 2'd2, 3'd2);
    exp_beats[base+5] = beat(3'd6, 2'd2, 3'd6);
    exp_beats[base+6] = beat(3'd2, 2'd3, 3'd1);
    exp_beats[base+7] = beat(3'd6, 2'd3, 3'd5);
  endtask

  // Line B: upper 6,5,4,3 / lower 1,2,3,4 at address 1
  task automatic set_exp_b(input int base);
    exp_beats[base+0] = beat(3'd1, 2'd0, 3'd3);
    exp_beats[base+1] = beat(3'd5, 2'd0, 3'd4);
    exp_beats[base+2] = beat(3'd1, 2'd1, 3'd4);
    exp_beats[base+3] = beat(3'd5, 2'd1, 3'd3);
    exp_beats[base+4] = beat(3'd1, 2'd2, 3'd5);
    exp_beats[base+5] = beat(3'd5, 2'd2, 3'd2);
    exp_beats[base+6] = beat(3'd1, 2'd3, 3'd6);
    exp_beats[base+7] = beat(3'd5, 2'd3, 3'd1);
  endtask

  task automatic shift_col(input logic [2:0] up, input logic [2:0] lo, input logic [1:0] addr);
    hub_rgb_upper = up;
    hub_rgb_lower = lo;
    hub_addr = addr;
    repeat (4) @(negedge clock);
    hub_clk = 1'b1;
    repeat (4) @(negedge clock);
    hub_clk = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic shift_a();
    shift_col(3'd1, 3'd5, 2'd2);
    shift_col(3'd2, 3'd6, 2'd2);
    shift_col(3'd3, 3'd7, 2'd2);
    shift_col(3'd4, 3'd0, 2'd2);
  endtask

  task automatic shift_b();
    shift_col(3'd6, 3'd1, 2'd1);
    shift_col(3'd5, 3'd2, 2'd1);
    shift_col(3'd4, 3'd3, 2'd1);
    shift_col(3'd3, 3'd4, 2'd1);
  endtask

  task automatic latch_window(output int fe_o, output int ov_o, output int vh_o);
    fe_o = 0; ov_o = 0; vh_o = 0;
    hub_lat = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) hub_lat = 1'b0;
      @(negedge clock);
      fe_o += int'(frame_error);
      ov_o += int'(overrun);
      vh_o += int'(write_valid);
    end
  endtask

  // Called at a negedge; checks each accepted beat against exp_beats[first..last-1]
  task automatic collect(input int first, input int last, input int stall_at, input bit continuous);
    int idx;
    int budget;
    int gaps;
    idx = first; budget = 0; gaps = 0;
    while (idx < last && budget < 300) begin
      if (!write_valid) gaps++;
      if (idx == stall_at && write_valid) begin
        write_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clock);
          chk("stall_hold", {24'd0, payload()}, {24'd0, exp_beats[idx]});
        end
        write_ready = 1'b1;
      end
      if (write_valid && write_ready) begin
        chk($sformatf("beat%0d", idx), {24'd0, payload()}, {24'd0, exp_beats[idx]});
        idx++;
      end
      ov_cnt += int'(overrun);
      @(negedge clock);
      budget++;
    end
    chk("beat_count", idx, last);
    if (continuous) chk("valid_gaps", gaps, 0);
  endtask

  initial begin
    set_exp_a(0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_valid", {31'd0, write_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_flags", {29'd0, frame_error, overrun, display_on}, 32'd0);
    chk("rst_payload", {24'd0, payload()}, 32'd0);

    // display_on follows hub_oe_n three edges later
    repeat (5) @(negedge clock);
    hub_oe_n = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    chk("disp_early", {31'd0, display_on}, 32'd0);
    @(posedge clock); #1;
    chk("disp_on", {31'd0, display_on}, 32'd1);
    @(negedge clock);
    hub_oe_n = 1'b1;
    repeat (4) @(negedge clock);
    chk("disp_off", {31'd0, display_on}, 32'd0);

    // Basic readout with latch latency and a 5-cycle stall on beat 3
    shift_a();
    hub_lat = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    chk("lat_early", {31'd0, write_valid}, 32'd0);
    @(posedge clock); #1;
    chk("lat_latency", {31'd0, write_valid}, 32'd1);
    chk("lat_busy", {31'd0, busy}, 32'd1);
    chk("first_payload", {24'd0, payload()}, {24'd0, exp_beats[0]});
    @(negedge clock);
    hub_lat = 1'b0;
    write_ready = 1'b1;
    collect(0, 8, 3, 1'b0);
    chk("basic_end_valid", {31'd0, write_valid}, 32'd0);
    chk("basic_end_busy", {31'd0, busy}, 32'd0);

    // Short line: three shifts then latch
    write_ready = 1'b0;
    shift_col(3'd7, 3'd7, 2'd3);
    shift_col(3'd7, 3'd7, 2'd3);
    shift_col(3'd7, 3'd7, 2'd3);
    latch_window(fe, ov, vh);
    chk("short_fe", fe, 1);
    chk("short_ov", ov, 0);
    chk("short_valid", vh, 0);

    // Overrun: valid latch while beat 2 is stalled
    shift_a();
    latch_window(fe, ov, vh);
    chk("ovr_first_fe", fe, 0);
    chk("ovr_first_valid", vh, 8);
    write_ready = 1'b1;
    collect(0, 2, -1, 1'b0);
    write_ready = 1'b0;
    shift_b();
    latch_window(fe, ov, vh);
    chk("ovr_pulse", ov, 1);
    chk("ovr_fe", fe, 0);
    chk("ovr_hold", {24'd0, payload()}, {24'd0, exp_beats[2]});
    write_ready = 1'b1;
    collect(2, 8, -1, 1'b0);
    chk("ovr_end_valid", {31'd0, write_valid}, 32'd0);
    vh = 0;
    repeat (10) begin @(negedge clock); vh += int'(write_valid); end
    chk("ovr_no_second", vh, 0);

    // Back-to-back: second latch lands on the final accepted beat
    set_exp_b(8);
    write_ready = 1'b0;
    shift_a();
    latch_window(fe, ov, vh);
    chk("b2b_fe", fe, 0);
    shift_b();
    write_ready = 1'b1;
    collect(0, 7, -1, 1'b0);
    write_ready = 1'b0;
    chk("b2b_final_held", {24'd0, payload()}, {24'd0, exp_beats[7]});
    hub_lat = 1'b1;
    @(posedge clock); @(negedge clock); @(posedge clock); @(negedge clock);
    write_ready = 1'b1;
    ov_cnt = 0;
    collect(7, 16, -1, 1'b1);
    hub_lat = 1'b0;
    chk("b2b_end_valid", {31'd0, write_valid}, 32'd0);
    chk("b2b_no_overrun", ov_cnt, 0);
    repeat (6) @(negedge clock);

    // Reset during beat 4 with hub_clk held high across the release
    write_ready = 1'b0;
    shift_a();
    latch_window(fe, ov, vh);
    write_ready = 1'b1;
    collect(0, 4, -1, 1'b0);
    chk("pre_reset_beat", {24'd0, payload()}, {24'd0, exp_beats[4]});
    reset = 1'b1;
    hub_clk = 1'b1;
    @(posedge clock); #1;
    chk("reset_drop_valid", {31'd0, write_valid}, 32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    write_ready = 1'b0;
    chk("reset_payload", {24'd0, payload()}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    vh = 0;
    repeat (8) begin @(negedge clock); vh += int'(write_valid); end
    hub_clk = 1'b0;
    repeat (4) begin @(negedge clock); vh += int'(write_valid); end
    chk("reset_discard", vh, 0);
    shift_a();
    latch_window(fe, ov, vh);
    chk("no_phantom_shift", fe, 0);
    write_ready = 1'b1;
    collect(0, 8, -1, 1'b0);
    chk("post_reset_end", {31'd0, write_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
